// File: rtl/bp_pkg.sv
// Shared definitions for the branch-predictor counter table controller:
// FSM encoding, init value and the 2-bit saturating counter update.
package bp_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_UPD_RD = 2'd2,
        ST_UPD_WR = 2'd3
    } bp_state_e;

    // Weakly not-taken.
    localparam logic [1:0] BP_INIT_VAL = 2'b01;

    function automatic logic [1:0] bp_ctr_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) nxt = ctr + 2'd1;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Update queue: circular buffer with count-based full/empty. Push is ignored
// when full and pop is ignored when empty, so callers can gate loosely.
module bp_upd_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_clr,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Arbitrates a single-port 2-bit counter table between fetch-stage prediction
// reads and queued read-modify-write updates from execute; also runs table init.
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int         IDX_BITS   = 8,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [1:0] INIT_VAL   = BP_INIT_VAL
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                soft_clear,
    input  logic                fetch_req,
    input  logic [31:0]         fetch_pc,
    output logic                fetch_stall,
    output logic                pred_valid,
    output logic                pred_taken,
    input  logic                exec_valid,
    input  logic [31:0]         exec_pc,
    input  logic                exec_taken,
    output logic                exec_ready,
    output logic                init_busy,
    output logic [IDX_BITS-1:0] tbl_addr,
    output logic                tbl_en,
    output logic                tbl_we,
    output logic [1:0]          tbl_wdata,
    input  logic [1:0]          tbl_rdata
);

    localparam int QW = IDX_BITS + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    bp_state_e           r_state;
    bp_state_e           w_state_nxt;
    logic [IDX_BITS-1:0] r_init_addr;
    logic [IDX_BITS-1:0] r_upd_idx;
    logic                r_upd_taken;
    logic                r_pred_valid;

    logic [IDX_BITS-1:0] w_fetch_idx;
    logic [IDX_BITS-1:0] w_exec_idx;
    logic                w_grant;
    logic                w_push;
    logic                w_pop;
    logic [QW-1:0]       w_head;
    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_fifo_count;
    logic                w_clr;
    logic                w_unused;

    assign w_fetch_idx = fetch_pc[IDX_BITS+1:2];
    assign w_exec_idx  = exec_pc[IDX_BITS+1:2];
    assign w_push      = exec_valid & exec_ready;
    // rst already forces the same outcome, so the clear only acts outside reset.
    assign w_clr       = soft_clear & ~rst;
    assign w_unused    = ^{fetch_pc[31:IDX_BITS+2], fetch_pc[1:0],
                           exec_pc[31:IDX_BITS+2], exec_pc[1:0], w_fifo_count};

    bp_upd_fifo #(
        .WIDTH (QW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_push  (w_push),
        .i_data  ({w_exec_idx, exec_taken}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_fifo_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_pop       = 1'b0;
        tbl_en      = 1'b0;
        tbl_we      = 1'b0;
        tbl_addr    = r_upd_idx;
        tbl_wdata   = INIT_VAL;
        init_busy   = 1'b0;
        exec_ready  = ~w_full & ~w_clr;
        case (r_state)
            ST_INIT: begin
                init_busy  = 1'b1;
                exec_ready = 1'b0;
                tbl_en     = 1'b1;
                tbl_we     = 1'b1;
                tbl_addr   = r_init_addr;
                if (r_init_addr == '1) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                // A full queue must drain or execute would stall indefinitely.
                if (w_full) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_UPD_RD;
                end else if (fetch_req) begin
                    w_grant  = 1'b1;
                    tbl_en   = 1'b1;
                    tbl_addr = w_fetch_idx;
                end else if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_UPD_RD;
                end
            end
            ST_UPD_RD: begin
                tbl_en      = 1'b1;
                w_state_nxt = ST_UPD_WR;
            end
            ST_UPD_WR: begin
                tbl_en      = 1'b1;
                tbl_we      = 1'b1;
                tbl_wdata   = bp_ctr_next(tbl_rdata, r_upd_taken);
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_INIT;
        endcase
        if (w_clr) begin
            w_state_nxt = ST_INIT;
            w_grant     = 1'b0;
            w_pop       = 1'b0;
            tbl_en      = 1'b0;
            tbl_we      = 1'b0;
        end
    end

    assign fetch_stall = fetch_req & ~w_grant;
    assign pred_valid  = r_pred_valid;
    assign pred_taken  = r_pred_valid & tbl_rdata[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_init_addr  <= '0;
            r_pred_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pred_valid <= w_grant;
            if (r_state == ST_INIT && !soft_clear)
                r_init_addr <= r_init_addr + 1'b1;
            else
                r_init_addr <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) {r_upd_idx, r_upd_taken} <= w_head;
    end

endmodule
